// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    typedef enum logic {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } mode_t;

    localparam int          CNT_W_DEFAULT       = 32;
    localparam int unsigned DEFAULT_DIV_DEFAULT = 5_000_000;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: FSM, period counter, and divisor/mode latches that
// only update at period boundaries so clk_out and tick never glitch.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel,
    input  logic [CNT_W-1:0] div_a,
    input  logic [CNT_W-1:0] div_b,
    input  logic             mode,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             div_err
);

    state_t           state_reg;
    mode_t            mode_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_reg;
    logic             clk_out_reg;
    logic             tick_reg;

    logic [CNT_W-1:0] div_sel;
    logic             div_sel_zero;
    logic             terminal;

    assign div_sel      = sel ? div_a : div_b;
    assign div_sel_zero = (div_sel == '0);
    // div_reg is never zero while in RUN, so D-1 cannot underflow there
    assign terminal     = (cnt_reg == (div_reg - CNT_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            mode_reg    <= TOGGLE;
            cnt_reg     <= '0;
            div_reg     <= DEFAULT_DIV;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg     <= '0;
                    clk_out_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                    if (en) begin
                        div_reg   <= div_sel;
                        mode_reg  <= mode_t'(mode);
                        state_reg <= div_sel_zero ? ERR : RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        clk_out_reg <= 1'b0;
                        tick_reg    <= 1'b0;
                    end else if (sync) begin
                        cnt_reg     <= '0;
                        clk_out_reg <= 1'b0;
                        tick_reg    <= 1'b0;
                    end else if (terminal) begin
                        cnt_reg <= '0;
                        if (div_sel_zero) begin
                            state_reg   <= ERR;
                            clk_out_reg <= 1'b0;
                            tick_reg    <= 1'b0;
                        end else begin
                            tick_reg    <= 1'b1;
                            clk_out_reg <= (mode_reg == PULSE) ? 1'b1 : ~clk_out_reg;
                            div_reg     <= div_sel;
                            mode_reg    <= mode_t'(mode);
                        end
                    end else begin
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                        tick_reg <= 1'b0;
                        if (mode_reg == PULSE) begin
                            clk_out_reg <= 1'b0;
                        end
                    end
                end
                ERR: begin
                    cnt_reg     <= '0;
                    clk_out_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                    if (!en) begin
                        state_reg <= IDLE;
                    end else if (!div_sel_zero) begin
                        div_reg   <= div_sel;
                        mode_reg  <= mode_t'(mode);
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign div_err = (state_reg == ERR);

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider; slices packed buses per channel.
// Define CLKDIV_SYNC_EN to add sync_in, which phase-aligns all running channels.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       sel,
    input  logic [NUM_CH*CNT_W-1:0] div_a,
    input  logic [NUM_CH*CNT_W-1:0] div_b,
    input  logic [NUM_CH-1:0]       mode,
`ifdef CLKDIV_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       div_err
);

    logic sync;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .en      (en[gi]),
            .sel     (sel[gi]),
            .div_a   (div_a[gi*CNT_W +: CNT_W]),
            .div_b   (div_b[gi*CNT_W +: CNT_W]),
            .mode    (mode[gi]),
            .sync    (sync),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi]),
            .div_err (div_err[gi])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (two channels, 16-bit).
module tb_multi_clock_divider;

    localparam int NCH = 2;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  en;
    logic [NCH-1:0]  sel;
    logic [NCH*CW-1:0] div_a;
    logic [NCH*CW-1:0] div_b;
    logic [NCH-1:0]  mode;
`ifdef CLKDIV_SYNC_EN
    logic            sync_in;
`endif
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  div_err;

    int total = 0;
    int bad   = 0;

    multi_clock_divider #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sel     (sel),
        .div_a   (div_a),
        .div_b   (div_b),
        .mode    (mode),
`ifdef CLKDIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .div_err (div_err)
    );

    always #5 clk = ~clk;

    // Advance n edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '0; sel = '0; div_a = '0; div_b = '0; mode = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in = 1'b0;
`endif
        step(2);
        total++;
        if ({clk_out, tick, div_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000", {clk_out, tick, div_err});
        end
        reset = 1'b0;
        step(3);
        total++;
        if ({clk_out, tick, div_err} !== 6'b0) begin
            bad++;
            $display("FAIL idle_outputs got=%b want=000000", {clk_out, tick, div_err});
        end
        $display("reset: outputs low");
    endtask

    task automatic test_toggle();
        logic [1:0] exp;
        sel[0] = 1'b1; div_a[0*CW +: CW] = 16'd4; mode[0] = 1'b0; en[0] = 1'b1;
        step(1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp = {1'((k / 4) % 2), 1'(k % 4 == 0)};
            total++;
            if ({clk_out[0], tick[0]} !== exp) begin
                bad++;
                $display("FAIL toggle k=%0d got clk/tick=%b want=%b", k, {clk_out[0], tick[0]}, exp);
            end
        end
        en[0] = 1'b0;
        step(1);
        total++;
        if ({clk_out[0], tick[0]} !== 2'b00) begin
            bad++;
            $display("FAIL toggle_en_off got=%b want=00", {clk_out[0], tick[0]});
        end
        step(1);
        $display("toggle: D=4 period 8 checked");
    endtask

    task automatic test_pulse();
        logic [1:0] exp;
        sel[1] = 1'b0; div_b[1*CW +: CW] = 16'd3; mode[1] = 1'b1; en[1] = 1'b1;
        step(1);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp = (k % 3 == 0) ? 2'b11 : 2'b00;
            total++;
            if ({clk_out[1], tick[1]} !== exp) begin
                bad++;
                $display("FAIL pulse3 k=%0d got clk/tick=%b want=%b", k, {clk_out[1], tick[1]}, exp);
            end
        end
        en[1] = 1'b0;
        step(1);
        div_b[1*CW +: CW] = 16'd1; en[1] = 1'b1;
        step(1);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            total++;
            if ({clk_out[1], tick[1]} !== 2'b11) begin
                bad++;
                $display("FAIL pulse1 k=%0d got clk/tick=%b want=11", k, {clk_out[1], tick[1]});
            end
        end
        en[1] = 1'b0;
        step(2);
        $display("pulse: D=3 and D=1 checked");
    endtask

    task automatic test_switch();
        logic exp_tick;
        logic exp_clk;
        exp_clk = 1'b0;
        sel[0] = 1'b1; div_a[0*CW +: CW] = 16'd5; div_b[0*CW +: CW] = 16'd2;
        mode[0] = 1'b0; en[0] = 1'b1;
        step(1);
        for (int k = 1; k <= 11; k++) begin
            step(1);
            exp_tick = (k == 5) || (k == 7) || (k == 9) || (k == 11);
            if (exp_tick) exp_clk = ~exp_clk;
            total++;
            if ({clk_out[0], tick[0]} !== {exp_clk, exp_tick}) begin
                bad++;
                $display("FAIL switch k=%0d got clk/tick=%b want=%b", k, {clk_out[0], tick[0]}, {exp_clk, exp_tick});
            end
            if (k == 2) sel[0] = 1'b0;
        end
        en[0] = 1'b0;
        step(2);
        $display("switch: 5 -> 2 at period boundary checked");
    endtask

    task automatic test_zero_div();
        sel[0] = 1'b1; div_a[0*CW +: CW] = 16'd0; mode[0] = 1'b0; en[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            total++;
            if ({div_err[0], clk_out[0], tick[0]} !== 3'b100) begin
                bad++;
                $display("FAIL zero_err k=%0d got err/clk/tick=%b want=100", k, {div_err[0], clk_out[0], tick[0]});
            end
        end
        div_a[0*CW +: CW] = 16'd6;
        step(1);
        total++;
        if (div_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL zero_recover_err got=%b want=0", div_err[0]);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1);
            total++;
            if ({clk_out[0], tick[0]} !== ((k == 6) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL zero_recover k=%0d got clk/tick=%b want=%b", k, {clk_out[0], tick[0]}, (k == 6) ? 2'b11 : 2'b00);
            end
        end
        en[0] = 1'b0;
        step(2);
        $display("zero divisor: ERR then RUN at D=6 checked");
    endtask

    task automatic test_async_reset();
        sel[0] = 1'b1; div_a[0*CW +: CW] = 16'd7; mode[0] = 1'b0; en[0] = 1'b1;
        sel[1] = 1'b0; div_b[1*CW +: CW] = 16'd0; en[1] = 1'b1;
        step(1);
        step(10);
        total++;
        if ({clk_out[0], div_err[1]} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset got clk0/err1=%b want=11", {clk_out[0], div_err[1]});
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({clk_out, tick, div_err} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=000000", {clk_out, tick, div_err});
        end
        en = '0;
        step(1);
        reset = 1'b0;
        step(2);
        total++;
        if ({clk_out, tick, div_err} !== 6'b0) begin
            bad++;
            $display("FAIL post_reset_idle got=%b want=000000", {clk_out, tick, div_err});
        end
        div_a[0*CW +: CW] = 16'd2; en[0] = 1'b1;
        step(1);
        step(2);
        total++;
        if ({clk_out[0], tick[0]} !== 2'b11) begin
            bad++;
            $display("FAIL post_reset_run got clk/tick=%b want=11", {clk_out[0], tick[0]});
        end
        en = '0;
        step(2);
        $display("async reset: outputs cleared without clock");
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        logic [1:0] exp;
        sel = 2'b11; mode = 2'b00;
        div_a[0*CW +: CW] = 16'd4; div_a[1*CW +: CW] = 16'd6;
        en[1] = 1'b1;
        step(2);
        en[0] = 1'b1;
        step(1);
        step(7);
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        total++;
        if ({clk_out, tick} !== 4'b0000) begin
            bad++;
            $display("FAIL sync_edge got clk/tick=%b want=0000", {clk_out, tick});
        end
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp = {1'(k == 6), 1'(k % 4 == 0)};
            total++;
            if (tick !== exp) begin
                bad++;
                $display("FAIL sync_align k=%0d got tick=%b want=%b", k, tick, exp);
            end
        end
        en = '0;
        step(2);
        $display("sync: channels realigned");
    endtask
`endif

    initial begin
        test_reset();
        test_toggle();
        test_pulse();
        test_switch();
        test_zero_div();
        test_async_reset();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised N-channel programmable clock divider generating per-channel divided clocks and single-cycle ticks from the board clock. Each channel selects between two divisors, runs in 50%-duty toggle mode or one-cycle pulse mode, and changes divisor or mode only at period boundaries, so outputs never glitch. It sits between the board clock and the counter/display logic, replacing fixed single-output dividers.

## Interface
- NUM_CH, 2, number of independent channels (1..8)
- CNT_W, 32, divisor and counter width
- DEFAULT_DIV, 5_000_000, active divisor after reset; must be less than 2^CNT_W
- clk  in  1  board clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- sel  in  NUM_CH  divisor select: 1 selects div_a, 0 selects div_b
- div_a  in  NUM_CH*CNT_W  divisor A; channel i uses bits [i*CNT_W +: CNT_W]
- div_b  in  NUM_CH*CNT_W  divisor B; same packing as div_a
- mode  in  NUM_CH  0 selects toggle mode, 1 selects pulse mode
- clk_out  out  NUM_CH  divided clock, registered
- tick  out  NUM_CH  one-cycle strobe at each terminal count, registered
- div_err  out  NUM_CH  high while the channel is stopped on a zero divisor
- sync_in  in  1  present only with CLKDIV_SYNC_EN

## Operation
- Per-channel FSM with states IDLE, RUN and ERR. Reset puts every channel in IDLE with counter=0, clk_out=0, tick=0, div_err=0, active divisor D=DEFAULT_DIV and latched mode=toggle.
- IDLE: outputs are low.
  - If en=1, latch D from the sel-selected divisor and latch mode.
  - If the latched D=0, go to ERR. Otherwise go to RUN with counter=0.
- RUN, each cycle:
  - If en=0: go to IDLE. Clear counter, clk_out and tick.
  - Else if counter==D-1 (terminal count):
    - counter<=0 and tick<=1.
    - In toggle mode, clk_out toggles. In pulse mode, clk_out<=1.
    - Re-latch D and mode from the current inputs.
    - If the new D=0, go to ERR instead.
  - Otherwise: counter<=counter+1 and tick<=0. In pulse mode, clk_out<=0.
- ERR: div_err=1, clk_out=0, tick=0.
  - If en=0, go to IDLE.
  - Otherwise, each cycle re-sample the selected divisor. If it is non-zero, latch it, latch mode and go to RUN with counter=0.
- Arithmetic: counter is CNT_W bits. The compare uses D-1 computed in CNT_W bits, which is safe because D≥1 in RUN. No wrap is possible because the counter never exceeds D-1.
- Changes to div_a, div_b, sel or mode in mid-period have no effect until the next terminal count.

## Timing
- Load edge: the edge at which the channel enters RUN.
- First tick: registered high exactly D cycles after the load edge. Subsequent ticks repeat every D cycles.
- Toggle mode: clk_out period is 2D cycles with 50% duty. When D=1, clk_out toggles every cycle and tick stays high continuously.
- Pulse mode: clk_out is high for one cycle every D cycles and coincides with tick. When D=1, clk_out and tick are both constantly high.
- en falling: outputs are low from the next edge.
- Asynchronous reset in mid-operation: all outputs clear immediately, with no clock required.

## Configuration
- CLKDIV_SYNC_EN defined:
  - Adds the sync_in port.
  - When sync_in=1 at an edge, every channel in RUN sets counter<=0, clk_out<=0 and tick<=0. This phase-aligns the channels.
  - sync takes priority over a terminal count on the same edge, so no tick is produced.
  - sync has no effect on channels in IDLE or ERR.
- CLKDIV_SYNC_EN undefined: the sync_in port is absent and channels free-run independently.

## Structure
- Package clkdiv_pkg holds:
  - the state enum (IDLE, RUN, ERR)
  - the mode enum (TOGGLE=0, PULSE=1)
  - CNT_W_DEFAULT and DEFAULT_DIV_DEFAULT constants
- Sub-module clkdiv_channel implements one channel (FSM, counter, latches) and is instantiated NUM_CH times with generate. The top level only slices the packed buses and distributes sync_in.

## Test plan
- Reset with en=0, then en[0]=1, sel=1, div_a=4, toggle mode -> tick[0] at cycles 4, 8, 12 after the load edge; clk_out[0] toggles at each tick (period 8).
- Pulse mode with div_b=3 and sel=0 -> clk_out and tick both high for one cycle every 3 cycles; also check D=1, where both stay constantly high.
- While running with D=5, switch sel at counter=2 to a divisor of 2 -> the current period completes at 5 cycles, then periods of 2 cycles follow. No short pulse occurs.
- Select a divisor of 0 -> div_err=1 and outputs stay low. Change the divisor to 6 -> RUN, with the first tick 6 cycles after the load edge and div_err=0.
- Assert reset with counter at 3 of 7 -> all outputs drop without a clock edge. After release, the channel returns to IDLE with D=DEFAULT_DIV.
- With CLKDIV_SYNC_EN, run channel 0 at D=4 and channel 1 at D=6 offset, then pulse sync_in on a terminal-count edge of channel 0 -> no tick that cycle; both channels restart aligned, with ticks at +4 and +6.
